// File: rtl/hpu_pkg.sv
// Shared HPU constants and types; local-memory bank arbiter section.
package hpu_pkg;

  localparam int unsigned LM_BANK_N     = 8;
  localparam int unsigned LM_IND_WTH    = 3;
  localparam int unsigned LM_REQ_N      = 4;
  localparam int unsigned LM_ADDR_WTH   = 18;
  localparam int unsigned LM_RD_LAT     = 2;
  localparam int unsigned LM_STARVE_LIM = 15;
  localparam int unsigned LM_STAT_WTH   = 16;

  typedef logic [$clog2(LM_REQ_N)-1:0] lm_req_idx_t;

  // Requester slots, index 0 is the highest fixed priority
  typedef enum lm_req_idx_t {
    LMREQ_VEC,
    LMREQ_MTX,
    LMREQ_NDMA,
    LMREQ_LSU
  } lm_req_e;

endpackage

// File: rtl/hpu_lm_prio_arb.sv
// Fixed-priority one-hot arbiter; promoted candidates outrank all non-promoted ones.
module hpu_lm_prio_arb
  import hpu_pkg::*;
#(
  parameter int unsigned NREQ = LM_REQ_N
) (
  input  logic [NREQ-1:0] cand,
  input  logic [NREQ-1:0] promote,
  output logic [NREQ-1:0] gnt_c
);

  logic [NREQ-1:0] prom;
  logic [NREQ-1:0] pool;

  // Isolate the lowest set bit of the winning pool
  always_comb begin
    prom  = cand & promote;
    pool  = (|prom) ? prom : cand;
    gnt_c = pool & (~pool + NREQ'(1));
  end

endmodule

// File: rtl/hpu_lm_bank_arb.sv
// Local-memory bank-conflict arbiter: per-bank grant, starvation ageing, read-response timing, conflict stats.
module hpu_lm_bank_arb
  import hpu_pkg::*;
#(
  parameter int unsigned NREQ       = LM_REQ_N,
  parameter int unsigned ADDR_WTH   = LM_ADDR_WTH,
  parameter int unsigned BANK_N     = LM_BANK_N,
  parameter int unsigned IND_WTH    = LM_IND_WTH,
  parameter int unsigned RD_LAT     = LM_RD_LAT,
  parameter int unsigned STARVE_LIM = LM_STARVE_LIM,
  parameter int unsigned STAT_WTH   = LM_STAT_WTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_vld_i,
  input  logic [NREQ-1:0]          req_we_i,
  input  logic [NREQ*ADDR_WTH-1:0] req_addr_i,
  output logic [NREQ-1:0]          req_rdy_o,
  output logic [NREQ-1:0]          rsp_vld_o,
  output logic [NREQ-1:0]          starve_o,
  input  logic                     clr_stat_i,
  output logic [STAT_WTH-1:0]      conflict_cnt_o
);

  localparam int unsigned AGE_WTH = $clog2(STARVE_LIM + 1);
  localparam logic [AGE_WTH-1:0] AGE_MAX = AGE_WTH'(STARVE_LIM);

  logic [NREQ-1:0][IND_WTH-1:0] bank;
  logic [NREQ-1:0]              cand [BANK_N];
  logic [NREQ-1:0]              gnt  [BANK_N];
  logic [NREQ-1:0][AGE_WTH-1:0] age;
  logic [NREQ-1:0][AGE_WTH-1:0] age_nxt;
  logic [NREQ-1:0]              promote;
  logic [RD_LAT-1:0][NREQ-1:0]  rd_pipe;
  logic                         conflict;
  logic                         addr_unused;

  // Lower address bits select the word inside a bank and are not needed here
  assign addr_unused = ^req_addr_i;

  // Bank decode and per-bank candidate masks
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bank[i]    = req_addr_i[i*ADDR_WTH + ADDR_WTH - 1 -: IND_WTH];
      promote[i] = (age[i] == AGE_MAX);
    end
    for (int b = 0; b < BANK_N; b++) begin
      for (int i = 0; i < NREQ; i++) begin
        cand[b][i] = req_vld_i[i] & (bank[i] == IND_WTH'(b));
      end
    end
  end

  for (genvar b = 0; b < BANK_N; b++) begin : g_bank
    hpu_lm_prio_arb #(
      .NREQ (NREQ)
    ) u_prio_arb (
      .cand    (cand[b]),
      .promote (promote),
      .gnt_c   (gnt[b])
    );
  end

  // A requester targets exactly one bank, so OR-ing the bank grants is one-hot per requester
  always_comb begin
    req_rdy_o = '0;
    for (int b = 0; b < BANK_N; b++) begin
      req_rdy_o = req_rdy_o | gnt[b];
    end
  end

  always_comb begin
    conflict = |(req_vld_i & ~req_rdy_o);
    for (int i = 0; i < NREQ; i++) begin
      if (!req_vld_i[i] || req_rdy_o[i]) begin
        age_nxt[i] = '0;
      end else if (age[i] != AGE_MAX) begin
        age_nxt[i] = age[i] + AGE_WTH'(1);
      end else begin
        age_nxt[i] = age[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      age      <= '0;
      starve_o <= '0;
    end else begin
      age <= age_nxt;
      for (int i = 0; i < NREQ; i++) begin
        starve_o[i] <= (age_nxt[i] == AGE_MAX);
      end
    end
  end

  // Read-response delay line, one bit per requester per stage
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= req_vld_i & req_rdy_o & ~req_we_i;
      for (int k = 1; k < RD_LAT; k++) begin
        rd_pipe[k] <= rd_pipe[k-1];
      end
    end
  end

  assign rsp_vld_o = rd_pipe[RD_LAT-1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      conflict_cnt_o <= '0;
    end else if (clr_stat_i) begin
      conflict_cnt_o <= '0;
    end else if (conflict && (conflict_cnt_o != '1)) begin
      conflict_cnt_o <= conflict_cnt_o + STAT_WTH'(1);
    end
  end

endmodule

// File: tb/tb_hpu_lm_bank_arb.sv
// Directed bench for hpu_lm_bank_arb with a cycle-level reference model and literal spot checks.
module tb_hpu_lm_bank_arb;
  import hpu_pkg::*;

  localparam int NR  = 4;
  localparam int AW  = 18;
  localparam int LIM = 15;
  localparam int LAT = 2;

  logic            clk;
  logic            rst_i;
  logic [NR-1:0]   vld;
  logic [NR-1:0]   we;
  logic [NR*AW-1:0] addr;
  logic [NR-1:0]   rdy;
  logic [NR-1:0]   rsp;
  logic [NR-1:0]   starve;
  logic            clr;
  logic [15:0]     cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int age_m [NR];
  int due   [NR][$];
  int cnt_m = 0;

  hpu_lm_bank_arb dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_vld_i      (vld),
    .req_we_i       (we),
    .req_addr_i     (addr),
    .req_rdy_o      (rdy),
    .rsp_vld_o      (rsp),
    .starve_o       (starve),
    .clr_stat_i     (clr),
    .conflict_cnt_o (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int bank_of(input int i);
    logic [2:0] b;
    b = addr[i*AW + AW - 1 -: 3];
    return int'(b);
  endfunction

  // Reference model: evaluated at each falling edge, then advanced to the next rising edge
  always @(negedge clk) begin : model
    logic [NR-1:0] er;
    logic [NR-1:0] es;
    logic [NR-1:0] ep;
    int best;
    if (!rst_i) begin
      for (int i = 0; i < NR; i++) begin
        age_m[i] = 0;
        due[i].delete();
      end
      cnt_m = 0;
      chk("rst_rsp", 32'(rsp), 0);
      chk("rst_starve", 32'(starve), 0);
      chk("rst_cnt", 32'(cnt), 0);
      if (vld == '0) chk("rst_rdy", 32'(rdy), 0);
    end else begin
      er = '0;
      for (int b = 0; b < 8; b++) begin
        best = -1;
        for (int i = 0; i < NR; i++)
          if (best < 0 && vld[i] && bank_of(i) == b && age_m[i] == LIM) best = i;
        for (int i = 0; i < NR; i++)
          if (best < 0 && vld[i] && bank_of(i) == b) best = i;
        if (best >= 0) er[best] = 1'b1;
      end
      for (int i = 0; i < NR; i++) begin
        es[i] = (age_m[i] == LIM);
        ep[i] = (due[i].size() > 0 && due[i][0] == cyc);
      end
      chk($sformatf("rdy@%0d", cyc), 32'(rdy), 32'(er));
      chk($sformatf("rsp@%0d", cyc), 32'(rsp), 32'(ep));
      chk($sformatf("starve@%0d", cyc), 32'(starve), 32'(es));
      chk($sformatf("cnt@%0d", cyc), 32'(cnt), 32'(cnt_m));
      for (int i = 0; i < NR; i++) begin
        if (ep[i]) void'(due[i].pop_front());
        if (vld[i] && er[i]) begin
          age_m[i] = 0;
          if (!we[i]) due[i].push_back(cyc + LAT);
        end else if (vld[i]) begin
          age_m[i] = (age_m[i] < LIM) ? age_m[i] + 1 : LIM;
        end else begin
          age_m[i] = 0;
        end
      end
      if (clr) cnt_m = 0;
      else if ((vld & ~er) != '0 && cnt_m < 65535) cnt_m++;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input int b);
    vld[i] = v;
    we[i]  = w;
    addr[i*AW +: AW] = 18'((b << 15) | (i * 64));
  endtask

  // Withdraw each request as soon as it is granted
  task automatic drain();
    logic [NR-1:0] nv;
    for (int k = 0; k < 40 && vld != '0; k++) begin
      @(negedge clk);
      nv = vld & ~rdy;
      tick();
      vld = nv;
    end
    chk("drain", 32'(vld), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    vld   = '0;
    we    = '0;
    addr  = '0;
    clr   = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();

    // Four requesters on distinct banks: all granted together, all read data 2 cycles later
    set_req(0, 1, 0, 0);
    set_req(1, 1, 0, 1);
    set_req(2, 1, 0, 5);
    set_req(3, 1, 0, 7);
    @(negedge clk);
    chk("t2_rdy", 32'(rdy), 32'hF);
    chk("t2_rsp0", 32'(rsp), 0);
    tick();
    vld = '0;
    @(negedge clk);
    chk("t2_rsp1", 32'(rsp), 0);
    tick();
    @(negedge clk);
    chk("t2_rsp2", 32'(rsp), 32'hF);
    chk("t2_cnt", 32'(cnt), 0);
    tick();

    // Three back-to-back reads, then three writes, on bank 4 from req3
    for (int pass = 0; pass < 2; pass++) begin
      set_req(3, 1, 1'(pass), 4);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (k < 3) chk($sformatf("t3_rdy p%0d k%0d", pass, k), 32'(rdy[3]), 1);
        chk($sformatf("t3_rsp p%0d k%0d", pass, k), 32'(rsp[3]),
            (pass == 0 && k >= 2 && k <= 4) ? 32'd1 : 32'd0);
        tick();
        if (k == 2) vld[3] = 1'b0;
      end
    end
    we = '0;

    // req0 and req3 fight on bank 2 until req3 is promoted
    set_req(0, 1, 0, 2);
    set_req(3, 1, 0, 2);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("t1_rdy0", 32'(rdy), 32'h1);
        chk("t1_starve0", 32'(starve), 0);
      end
      if (k == 14) chk("t1_starve14", 32'(starve), 0);
      if (k == 15) begin
        chk("t1_rdy15", 32'(rdy), 32'h8);
        chk("t1_starve15", 32'(starve), 32'h8);
      end
      tick();
    end
    drain();

    // req1 and req2 both starve behind req0 on bank 3
    set_req(0, 1, 0, 3);
    set_req(1, 1, 0, 3);
    set_req(2, 1, 0, 3);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 15) begin
        chk("t4_rdy15", 32'(rdy), 32'h2);
        chk("t4_starve15", 32'(starve), 32'h6);
      end
      if (k == 16) begin
        chk("t4_rdy16", 32'(rdy), 32'h4);
        chk("t4_starve16", 32'(starve), 32'h4);
      end
      tick();
      if (k == 15) vld[1] = 1'b0;
    end
    drain();

    // Reset right after an accepted read discards its response
    set_req(2, 1, 0, 6);
    @(negedge clk);
    chk("t5_rdy", 32'(rdy), 32'h4);
    tick();
    vld   = '0;
    rst_i = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    rst_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t5_rsp k%0d", k), 32'(rsp), 0);
      chk($sformatf("t5_starve k%0d", k), 32'(starve), 0);
      tick();
    end

    // Reset while req3 is saturated: first cycle afterwards is plain fixed priority
    set_req(0, 1, 0, 2);
    set_req(3, 1, 0, 2);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      tick();
    end
    vld   = '0;
    rst_i = 1'b0;
    @(negedge clk);
    tick();
    rst_i = 1'b1;
    set_req(0, 1, 0, 2);
    set_req(3, 1, 0, 2);
    @(negedge clk);
    chk("t5b_rdy", 32'(rdy), 32'h1);
    chk("t5b_starve", 32'(starve), 0);
    tick();
    drain();

    // Persistent conflict saturates the statistic; clear beats increment
    set_req(0, 1, 0, 0);
    set_req(1, 1, 0, 0);
    repeat (65540) tick();
    @(negedge clk);
    chk("t6_sat", 32'(cnt), 32'hFFFF);
    tick();
    clr = 1'b1;
    @(negedge clk);
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("t6_clr", 32'(cnt), 0);
    tick();
    @(negedge clk);
    chk("t6_inc", 32'(cnt), 1);
    tick();
    drain();

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
